alu_exec_stage: RTL

//  Parametrised execute stage: decodes Itype ALU_mid / Rtype funct, performs the ALU op
//  and registers the result. Adds an iterative shift-add multiplier with HI/LO registers.

---
 rtl/alu_exec_stage.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_stage
// Desc     : Execute stage. Decodes Itype/Rtype ALU ops, registers the result,
//            and runs an iterative shift-add multiplier into HI/LO. Defining
//            ALU_DIV_EN adds a restoring divider (div/divu).
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [5:0]       funct_i,
  input  logic [2:0]       alu_mid_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             overflow_o,
  output logic             illegal_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [4:0] {
    OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_XNOR,
    OP_SLT, OP_SLTU, OP_MULT, OP_MULTU, OP_MFHI, OP_MFLO, OP_DIV, OP_DIVU,
    OP_ILL
  } op_e;

`ifdef ALU_DIV_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2, S_DIV = 2'd3} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_e;
`endif

  state_e              state_q, state_d;
  op_e                 w_op;
  logic                out_valid_q, overflow_q, illegal_q, neg_q;
  logic [WIDTH-1:0]    result_q, hi_q, lo_q, mcand_q;
  logic [2*WIDTH-1:0]  prod_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                w_accept, w_is_mul, w_multi, w_signed, w_last;
  logic [WIDTH-1:0]    w_mag_a, w_mag_b, w_sum, w_diff;
  logic [WIDTH-1:0]    w_alu_res, w_lo_init, w_mcand_init;
  logic                w_alu_ovf, w_alu_ill;
  logic [WIDTH:0]      w_add;
  logic [2*WIDTH-1:0]  w_mul_next, w_mul_fix;

  // alu_mid 110/111 hand decode over to the Rtype funct field
  always_comb begin
    w_op = OP_ILL;
    case (alu_mid_i)
      3'b000:  w_op = OP_ADD;
      3'b001:  w_op = OP_SUB;
      3'b010:  w_op = OP_AND;
      3'b011:  w_op = OP_OR;
      3'b100:  w_op = OP_XOR;
      3'b101:  w_op = OP_SLT;
      default: begin
        case (funct_i)
          6'b100000: w_op = OP_ADD;
          6'b100001: w_op = OP_ADDU;
          6'b100010: w_op = OP_SUB;
          6'b100011: w_op = OP_SUBU;
          6'b100100: w_op = OP_AND;
          6'b100101: w_op = OP_OR;
          6'b100110: w_op = OP_XOR;
          6'b001100: w_op = OP_XNOR;
          6'b101010: w_op = OP_SLT;
          6'b101011: w_op = OP_SLTU;
          6'b011000: w_op = OP_MULT;
          6'b011001: w_op = OP_MULTU;
          6'b010000: w_op = OP_MFHI;
          6'b010010: w_op = OP_MFLO;
`ifdef ALU_DIV_EN
          6'b011010: w_op = OP_DIV;
          6'b011011: w_op = OP_DIVU;
`endif
          default:   w_op = OP_ILL;
        endcase
      end
    endcase
  end

  assign w_sum  = op_a_i + op_b_i;
  assign w_diff = op_a_i - op_b_i;

  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    w_alu_ill = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (op_a_i[WIDTH-1] == op_b_i[WIDTH-1]) && (w_sum[WIDTH-1] != op_a_i[WIDTH-1]);
      end
      OP_ADDU: w_alu_res = w_sum;
      OP_SUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = (op_a_i[WIDTH-1] != op_b_i[WIDTH-1]) && (w_diff[WIDTH-1] != op_a_i[WIDTH-1]);
      end
      OP_SUBU: w_alu_res = w_diff;
      OP_AND:  w_alu_res = op_a_i & op_b_i;
      OP_OR:   w_alu_res = op_a_i | op_b_i;
      OP_XOR:  w_alu_res = op_a_i ^ op_b_i;
      OP_XNOR: w_alu_res = ~(op_a_i ^ op_b_i);
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
      OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (op_a_i < op_b_i)};
      OP_MFHI: w_alu_res = hi_q;
      OP_MFLO: w_alu_res = lo_q;
      OP_ILL:  w_alu_ill = 1'b1;
      default: ;
    endcase
  end

  assign in_ready_o = (state_q == S_IDLE);
  assign w_accept   = in_valid_i & in_ready_o;
  assign w_is_mul   = (w_op == OP_MULT) || (w_op == OP_MULTU);
  assign w_signed   = (w_op == OP_MULT) || (w_op == OP_DIV);
  // Both engines work on magnitudes; the sign is restored on the final step
  assign w_mag_a    = (w_signed && op_a_i[WIDTH-1]) ? -op_a_i : op_a_i;
  assign w_mag_b    = (w_signed && op_b_i[WIDTH-1]) ? -op_b_i : op_b_i;
  assign w_last     = (cnt_q == '0);

  assign w_add      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + ({1'b0, mcand_q} & {(WIDTH+1){prod_q[0]}});
  assign w_mul_next = {w_add, prod_q[WIDTH-1:1]};
  assign w_mul_fix  = neg_q ? -w_mul_next : w_mul_next;

`ifdef ALU_DIV_EN
  logic                w_is_div, rneg_q, dz_q, w_ge;
  logic [WIDTH:0]      w_shift;
  logic [WIDTH+1:0]    w_trial;
  logic [2*WIDTH-1:0]  w_div_next;
  logic [WIDTH-1:0]    w_quo_fix, w_rem_fix;

  assign w_is_div     = (w_op == OP_DIV) || (w_op == OP_DIVU);
  assign w_multi      = w_is_mul | w_is_div;
  assign w_lo_init    = w_is_div ? w_mag_a : w_mag_b;
  assign w_mcand_init = w_is_div ? w_mag_b : w_mag_a;
  // Upper half holds the partial remainder, lower half shifts dividend out / quotient in
  assign w_shift      = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign w_trial      = {1'b0, w_shift} - {2'b00, mcand_q};
  assign w_ge         = ~w_trial[WIDTH+1];
  assign w_div_next   = {(w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0]), prod_q[WIDTH-2:0], w_ge};
  assign w_quo_fix    = dz_q ? {WIDTH{1'b1}} :
                        (neg_q ? -w_div_next[WIDTH-1:0] : w_div_next[WIDTH-1:0]);
  assign w_rem_fix    = rneg_q ? -w_div_next[2*WIDTH-1:WIDTH] : w_div_next[2*WIDTH-1:WIDTH];
`else
  assign w_multi      = w_is_mul;
  assign w_lo_init    = w_mag_b;
  assign w_mcand_init = w_mag_a;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept && w_is_mul) state_d = S_MUL;
`ifdef ALU_DIV_EN
        if (w_accept && w_is_div) state_d = S_DIV;
`endif
      end
      S_MUL:  if (w_last) state_d = S_DONE;
`ifdef ALU_DIV_EN
      S_DIV:  if (w_last) state_d = S_DONE;
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // HI/LO and the result commit on the last iteration, so out_valid is seen in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      prod_q      <= '0;
      mcand_q     <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
`ifdef ALU_DIV_EN
      rneg_q      <= 1'b0;
      dz_q        <= 1'b0;
`endif
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            if (w_multi) begin
              prod_q  <= {{WIDTH{1'b0}}, w_lo_init};
              mcand_q <= w_mcand_init;
              cnt_q   <= CNT_W'(WIDTH - 1);
              neg_q   <= w_signed & (op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1]);
`ifdef ALU_DIV_EN
              rneg_q  <= w_signed & op_a_i[WIDTH-1];
              dz_q    <= (op_b_i == '0);
`endif
            end else begin
              out_valid_q <= 1'b1;
              result_q    <= w_alu_res;
              overflow_q  <= w_alu_ovf;
              illegal_q   <= w_alu_ill;
            end
          end
        end
        S_MUL: begin
          prod_q <= w_mul_next;
          if (w_last) begin
            hi_q        <= w_mul_fix[2*WIDTH-1:WIDTH];
            lo_q        <= w_mul_fix[WIDTH-1:0];
            result_q    <= w_mul_fix[WIDTH-1:0];
            out_valid_q <= 1'b1;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
`ifdef ALU_DIV_EN
        S_DIV: begin
          prod_q <= w_div_next;
          if (w_last) begin
            hi_q        <= w_rem_fix;
            lo_q        <= w_quo_fix;
            result_q    <= w_quo_fix;
            out_valid_q <= 1'b1;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign overflow_o  = overflow_q;
  assign illegal_o   = illegal_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;

endmodule
`default_nettype wire
